seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/mul_pkg.sv | 12 +
 rtl/seq_multiplier_if.sv | 28 ++
 rtl/mul_sign_mag.sv | 18 +
 rtl/seq_multiplier.sv | 134 +++++++++++++
 tb/tb_seq_multiplier.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential arithmetic units.
package mul_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage : mul_pkg

// File: rtl/seq_multiplier_if.sv
// Operand/product handshake bundle for seq_multiplier.
interface seq_multiplier_if
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  localparam int unsigned OUT_WIDTH = 2 * WIDTH;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 flush;
  logic [OUT_WIDTH-1:0] o;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_valid, a, b, signed_mode, flush, out_ready,
    input  in_ready, o, out_valid
  );

  modport slave (
    input  in_valid, a, b, signed_mode, flush, out_ready,
    output in_ready, o, out_valid
  );
endinterface : seq_multiplier_if

// File: rtl/mul_sign_mag.sv
// Combinational magnitude/sign split of one operand; -2^(WIDTH-1) maps to 2^(WIDTH-1).
module mul_sign_mag
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] mag_c,
  output logic             neg_c
);

  always_comb begin
    neg_c = signed_mode & x[WIDTH-1];
    mag_c = neg_c ? (~x + WIDTH'(1)) : x;
  end

endmodule : mul_sign_mag

// File: rtl/seq_multiplier.sv
// Shift-and-add sign-magnitude multiplier with early termination on the multiplier's top set bit.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  seq_multiplier_if.slave bus
);

  localparam int unsigned OUT_WIDTH = 2 * WIDTH;
  localparam int unsigned CNT_W     = $clog2(WIDTH) + 1;

  mul_state_e           state, state_d;
  logic [WIDTH-1:0]     a_mag, a_mag_d;
  logic [WIDTH-1:0]     b_reg, b_reg_d;
  logic [OUT_WIDTH-1:0] acc, acc_d;
  logic [OUT_WIDTH-1:0] acc_sum;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 negate, negate_d;
  logic [OUT_WIDTH-1:0] o_q, o_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;

  logic [WIDTH-1:0]     a_mag_c, b_mag_c;
  logic                 a_neg_c, b_neg_c;

  mul_sign_mag #(.WIDTH(WIDTH)) u_sign_mag_a (
    .x           (bus.a),
    .signed_mode (bus.signed_mode),
    .mag_c       (a_mag_c),
    .neg_c       (a_neg_c)
  );

  mul_sign_mag #(.WIDTH(WIDTH)) u_sign_mag_b (
    .x           (bus.b),
    .signed_mode (bus.signed_mode),
    .mag_c       (b_mag_c),
    .neg_c       (b_neg_c)
  );

  // State and datapath registers; reset overrides flush and handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_mag       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      cnt         <= '0;
      negate      <= 1'b0;
      o_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state       <= state_d;
      a_mag       <= a_mag_d;
      b_reg       <= b_reg_d;
      acc         <= acc_d;
      cnt         <= cnt_d;
      negate      <= negate_d;
      o_q         <= o_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state;
    a_mag_d     = a_mag;
    b_reg_d     = b_reg;
    acc_d       = acc;
    cnt_d       = cnt;
    negate_d    = negate;
    o_d         = o_q;
    out_valid_d = out_valid_q;
    acc_sum     = acc + (OUT_WIDTH'(a_mag) << cnt);

    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          a_mag_d  = a_mag_c;
          b_reg_d  = b_mag_c;
          negate_d = a_neg_c ^ b_neg_c;
          acc_d    = '0;
          cnt_d    = '0;
          if ((a_mag_c == '0) || (b_mag_c == '0)) begin
            state_d     = DONE;
            o_d         = '0;
            out_valid_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (b_reg[0]) begin
          acc_d = acc_sum;
        end
        b_reg_d = b_reg >> 1;
        cnt_d   = cnt + CNT_W'(1);
        // Stop as soon as no multiplier bits remain above the current one.
        if (b_reg_d == '0) begin
          state_d     = DONE;
          o_d         = negate ? (~acc_d + OUT_WIDTH'(1)) : acc_d;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (bus.flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end

    in_ready_d = (state_d == IDLE);
  end

  assign bus.o         = o_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH = 8: vector table, corner sequences, random traffic.
module tb_seq_multiplier;

  localparam int unsigned W  = 8;
  localparam int unsigned OW = 2 * W;
  localparam int          TIMEOUT = 40;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sm;
    logic [OW-1:0] exp_o;
    int            exp_lat;
    int            hold;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer product and latency from the multiplier magnitude.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                       output logic [OW-1:0] o, output int lat);
    int ai, bi, am, bm, p, k;
    ai = (sm && a[W-1]) ? int'(a) - 256 : int'(a);
    bi = (sm && b[W-1]) ? int'(b) - 256 : int'(b);
    p  = ai * bi;
    o  = p[OW-1:0];
    am = (ai < 0) ? -ai : ai;
    bm = (bi < 0) ? -bi : bi;
    if (am == 0 || bm == 0) begin
      lat = 1;
    end else begin
      k = 0;
      while ((bm >> k) != 0) k++;
      lat = k + 1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.in_ready && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
  endtask

  // Present operands for one accept cycle, then scramble the inputs.
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    wait_idle();
    bus.in_valid    = 1'b1;
    bus.a           = a;
    bus.b           = b;
    bus.signed_mode = sm;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.a           = W'($urandom);
    bus.b           = W'($urandom);
    bus.signed_mode = 1'($urandom);
  endtask

  task automatic run_txn(input vec_t v, input string name);
    int n;
    logic [OW-1:0] held;
    accept_op(v.a, v.b, v.sm);
    n = 1;
    while (!bus.out_valid && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(v.exp_lat));
    check({name, "_o"}, 64'(bus.o), 64'(v.exp_o));
    held = bus.o;
    for (int i = 0; i < v.hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      @(posedge clk); #1;
      check({name, "_hold_o"}, 64'(bus.o), 64'(held));
      check({name, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({name, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({name, "_drain_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, "_drain_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                              input logic [OW-1:0] o, input int lat, input int hold);
    vec_t v;
    v.a = a; v.b = b; v.sm = sm; v.exp_o = o; v.exp_lat = lat; v.hold = hold;
    return v;
  endfunction

  vec_t vecs [12];

  initial begin
    vec_t v;
    logic [OW-1:0] mo;
    int ml;

    vecs[0]  = mk(8'hFF, 8'hFF, 1'b0, 16'hFE01, 9, 0);
    vecs[1]  = mk(8'hFD, 8'h05, 1'b1, 16'hFFF1, 4, 0);
    vecs[2]  = mk(8'h80, 8'h80, 1'b1, 16'h4000, 9, 0);
    vecs[3]  = mk(8'h00, 8'hC8, 1'b0, 16'h0000, 1, 0);
    vecs[4]  = mk(8'hC8, 8'h00, 1'b0, 16'h0000, 1, 0);
    vecs[5]  = mk(8'h07, 8'h06, 1'b0, 16'h002A, 4, 5);
    vecs[6]  = mk(8'h80, 8'h01, 1'b1, 16'hFF80, 2, 0);
    vecs[7]  = mk(8'h80, 8'h01, 1'b0, 16'h0080, 2, 0);
    vecs[8]  = mk(8'hFF, 8'hFF, 1'b1, 16'h0001, 2, 1);
    vecs[9]  = mk(8'h7F, 8'h80, 1'b1, 16'hC080, 9, 0);
    vecs[10] = mk(8'h80, 8'h00, 1'b1, 16'h0000, 1, 2);
    vecs[11] = mk(8'hFF, 8'h80, 1'b0, 16'h7F80, 9, 0);

    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.signed_mode = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_o", 64'(bus.o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset one cycle at T+2 of a long transaction.
    accept_op(8'hFF, 8'hFF, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    expect_quiet("rst_mid_quiet", 12);
    run_txn(mk(8'h03, 8'h04, 1'b0, 16'h000C, 4, 0), "post_rst");

    // Flush during CALC.
    accept_op(8'hFF, 8'hFF, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_calc_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_calc_out_valid", 64'(bus.out_valid), 64'd0);
    expect_quiet("flush_calc_quiet", 12);

    // Flush while DONE is stalled.
    accept_op(8'h02, 8'h03, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    check("flush_done_pre_valid", 64'(bus.out_valid), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_done_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_done_in_ready", 64'(bus.in_ready), 64'd1);

    // Flush wins over an accept in IDLE.
    bus.in_valid = 1'b1;
    bus.a = 8'h05;
    bus.b = 8'h05;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    check("flush_idle_in_ready", 64'(bus.in_ready), 64'd1);
    expect_quiet("flush_idle_quiet", 12);

    for (int i = 0; i < 200; i++) begin
      v.a  = W'($urandom);
      v.b  = W'($urandom);
      v.sm = 1'($urandom);
      if ($urandom_range(0, 7) == 0) v.b = '0;
      if ($urandom_range(0, 7) == 0) v.a = 8'h80;
      model(v.a, v.b, v.sm, mo, ml);
      v.exp_o   = mo;
      v.exp_lat = ml;
      v.hold    = int'($urandom_range(0, 2));
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_seq_multiplier
